cmp_seq_unit: RTL

- Parametrised successor to the team's 16-bit equality comparator, used as the branch-condition evaluator in the custom RISC execute stage.
- Compares two WIDTH-bit operands serially, CHUNK bits per cycle, starting at the MSB chunk. It trades latency for area.
- Supports six compare modes: equality, inequality, and signed/unsigned ordering.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall around it.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/chunk_cmp.sv | 19 +
 rtl/cmp_seq_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: compare-mode constants, FSM encoding and mode helpers shared by the serial comparator
package cmp_pkg;
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_LTU = 3'd3;
  localparam logic [2:0] CMP_GE  = 3'd4;
  localparam logic [2:0] CMP_GEU = 3'd5;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;
  function automatic logic is_signed(input logic [2:0] m);
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction
  function automatic logic mode_result(input logic [2:0] m, input logic eq, input logic lt);
    return m == CMP_EQ ? eq :
           m == CMP_NE ? !eq :
           (m == CMP_LT || m == CMP_LTU) ? lt :
           (m == CMP_GE || m == CMP_GEU) ? !lt : 1'b0;
  endfunction
endpackage

// File: rtl/chunk_cmp.sv
// chunk_cmp: one CHUNK-bit slice compare; flip_sign turns the unsigned compare into a signed one
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_sign,
  output logic             eq,
  output logic             lt
);
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);
  logic [CHUNK-1:0] a_x, b_x;
  always_comb begin
    a_x = flip_sign ? a ^ MSB : a;
    b_x = flip_sign ? b ^ MSB : b;
    eq  = a == b;
    lt  = a_x < b_x;
  end
endmodule

// File: rtl/cmp_seq_unit.sv
// cmp_seq_unit: serial MSB-first operand comparator with valid/ready handshakes on both sides
module cmp_seq_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             a_eq_b,
  output logic             a_lt_b
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0] mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d;
  logic decided_q, decided_d, eq_q, eq_d, lt_q, lt_d, result_q, result_d;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic c_eq, c_lt, accept, last, upd_diff, upd_eq;
  assign a_ch = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_ch = b_q[int'(idx_q)*CHUNK +: CHUNK];
  chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
    .a         (a_ch),
    .b         (b_ch),
    .flip_sign (is_signed(mode_q) && idx_q == TOP),
    .eq        (c_eq),
    .lt        (c_lt)
  );
  assign accept = in_valid && state_q == IDLE;
  assign last   = idx_q == '0 || (EARLY_EXIT != 0 && !c_eq);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (in_valid ? SCAN : IDLE) :
              state_q == SCAN ? (last ? DONE : SCAN) :
              state_q == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    result    = result_q;
    a_eq_b    = eq_q;
    a_lt_b    = lt_q;
  end
  // The first differing chunk decides; later chunks never override it
  always_comb begin
    upd_diff  = state_q == SCAN && !decided_q && !c_eq;
    upd_eq    = state_q == SCAN && !decided_q && c_eq && idx_q == '0;
    a_d       = accept ? ina : a_q;
    b_d       = accept ? inb : b_q;
    mode_d    = accept ? mode : mode_q;
    idx_d     = accept ? TOP : (state_q == SCAN && !last) ? idx_q - IW'(1) : idx_q;
    decided_d = accept ? 1'b0 : (state_q == SCAN && !c_eq) ? 1'b1 : decided_q;
    eq_d      = upd_diff ? 1'b0 : upd_eq ? 1'b1 : eq_q;
    lt_d      = upd_diff ? c_lt : upd_eq ? 1'b0 : lt_q;
    result_d  = state_q == SCAN ? mode_result(mode_q, eq_d, lt_d) : result_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      result_q  <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      result_q  <= result_d;
    end
endmodule
